// File: rtl/fetch_decode_queue.sv
// Fetch-to-decode decoupling queue for the pipelined LC-3b core.
// Circular buffer of {instr, pc, pcplus2}. The head is shown as a NOP whenever the queue is empty.
module fetch_decode_queue #(
    parameter int DEPTH = 2,
    parameter int CW    = 2
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [15:0]   in_instr,
    input  logic [15:0]   in_pc,
    input  logic [15:0]   in_pcplus2,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [15:0]   out_instr,
    output logic [15:0]   out_pc,
    output logic [15:0]   out_pcplus2,
    output logic [CW-1:0] count,
    output logic [15:0]   bubble_cycles
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc;
        logic [15:0] pcplus2;
    } entry_t;

    entry_t          mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [15:0]     bubble_q, bubble_d;
    logic            push, pop;
    entry_t          head;

    // in_ready depends only on registered occupancy, so decode never stalls fetch combinationally.
    assign in_ready  = (count_q < DEPTH_C);
    assign out_valid = (count_q != '0);
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;

    assign head        = mem_q[rd_ptr_q];
    assign out_instr   = head.instr   & {16{out_valid}};
    assign out_pc      = head.pc      & {16{out_valid}};
    assign out_pcplus2 = head.pcplus2 & {16{out_valid}};

    assign count         = count_q;
    assign bubble_cycles = bubble_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        bubble_d = bubble_q;

        if (!out_valid && bubble_q != 16'hFFFF) begin
            bubble_d = bubble_q + 16'd1;
        end

        if (flush) begin
            // Pointers are not rewound; the queue simply restarts empty at wr_ptr.
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            if (push && !pop)      count_d = count_q + CW'(1);
            else if (pop && !push) count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            bubble_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            bubble_q <= bubble_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n && push) begin
            mem_q[wr_ptr_q] <= '{instr: in_instr, pc: in_pc, pcplus2: in_pcplus2};
        end
    end

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Directed bench for fetch_decode_queue: a queue-based reference model checked every cycle,
// plus hand-computed literal expectations at key points.
module tb_fetch_decode_queue;
    localparam int DEPTH = 2;
    localparam int CW    = 2;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [15:0]   in_instr;
    logic [15:0]   in_pc;
    logic [15:0]   in_pcplus2;
    logic          out_valid;
    logic          out_ready;
    logic [15:0]   out_instr;
    logic [15:0]   out_pc;
    logic [15:0]   out_pcplus2;
    logic [CW-1:0] count;
    logic [15:0]   bubble_cycles;

    int checks = 0;
    int errors = 0;

    fetch_decode_queue #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .in_pcplus2(in_pcplus2),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc), .out_pcplus2(out_pcplus2),
        .count(count), .bubble_cycles(bubble_cycles)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: FIFO of {instr, pc, pcplus2} entries and a bubble counter
    logic [47:0] mq[$];
    int          m_bub = 0;
    bit          started = 0;

    always @(posedge clk) begin
        if (!reset_n) begin
            mq.delete();
            m_bub   = 0;
            started = 1;
        end else if (started) begin
            bit do_push, do_pop;
            if (mq.size() == 0 && m_bub < 65535) m_bub++;
            do_pop  = (mq.size() != 0) && out_ready && !flush;
            do_push = in_valid && (mq.size() < DEPTH) && !flush;
            if (flush) mq.delete();
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back({in_instr, in_pc, in_pcplus2});
        end
    end

    // scoreboard compare, away from the active edge
    always @(negedge clk) begin
        if (started) begin
            logic [47:0] h;
            h = (mq.size() != 0) ? mq[0] : 48'h0;
            chk("out_valid",   32'(out_valid),     32'(mq.size() != 0));
            chk("in_ready",    32'(in_ready),      32'(mq.size() < DEPTH));
            chk("count",       32'(count),         32'(mq.size()));
            chk("out_instr",   32'(out_instr),     32'(h[47:32]));
            chk("out_pc",      32'(out_pc),        32'(h[31:16]));
            chk("out_pcplus2", 32'(out_pcplus2),   32'(h[15:0]));
            chk("bubble",      32'(bubble_cycles), 32'(m_bub));
        end
    end

    // driver: present inputs for one cycle, return 1 time unit after the edge
    task automatic step(input logic v, input logic [15:0] ins, input logic [15:0] pc,
                        input logic ordy, input logic fl);
        in_valid   = v;
        in_instr   = ins;
        in_pc      = pc;
        in_pcplus2 = pc + 16'd2;
        out_ready  = ordy;
        flush      = fl;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_pc = '0; in_pcplus2 = '0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_instr", 32'(out_instr), 32'h0);

        // single push, visible the next cycle
        step(1, 16'h1234, 16'h3000, 0, 0);
        chk("t1_valid", 32'(out_valid), 32'd1);
        chk("t1_instr", 32'(out_instr), 32'h1234);
        chk("t1_pc", 32'(out_pc), 32'h3000);
        chk("t1_pcp2", 32'(out_pcplus2), 32'h3002);
        chk("t1_count", 32'(count), 32'd1);
        step(0, 16'h0, 16'h0, 1, 0);
        chk("t1_drain", 32'(count), 32'd0);

        // fill to full; third push refused
        step(1, 16'hA001, 16'h3010, 0, 0);
        step(1, 16'hB002, 16'h3012, 0, 0);
        chk("t2_count_full", 32'(count), 32'd2);
        chk("t2_in_ready", 32'(in_ready), 32'd0);
        step(1, 16'hC003, 16'h3014, 0, 0);
        chk("t2_c_refused", 32'(count), 32'd2);
        chk("t2_head_a", 32'(out_instr), 32'hA001);
        step(0, 16'h0, 16'h0, 1, 0);
        chk("t2_head_b", 32'(out_instr), 32'hB002);
        step(0, 16'h0, 16'h0, 1, 0);
        chk("t2_empty", 32'(out_valid), 32'd0);
        step(1, 16'hC003, 16'h3014, 0, 0);
        chk("t2_head_c", 32'(out_instr), 32'hC003);
        step(0, 16'h0, 16'h0, 1, 0);

        // full with in_valid and out_ready together: pop only
        step(1, 16'hA001, 16'h3020, 0, 0);
        step(1, 16'hB002, 16'h3022, 0, 0);
        step(1, 16'hD004, 16'h3024, 1, 0);
        chk("t3_count", 32'(count), 32'd1);
        chk("t3_head_b", 32'(out_instr), 32'hB002);
        step(1, 16'hE005, 16'h3026, 1, 0);
        chk("t3_count_same", 32'(count), 32'd1);
        chk("t3_head_e", 32'(out_instr), 32'hE005);
        chk("t3_pc_e", 32'(out_pc), 32'h3026);
        step(0, 16'h0, 16'h0, 1, 0);

        // flush with a concurrent push
        step(1, 16'hA001, 16'h3030, 0, 0);
        step(1, 16'hB002, 16'h3032, 0, 0);
        step(1, 16'hF006, 16'h3034, 0, 1);
        chk("t4_valid", 32'(out_valid), 32'd0);
        chk("t4_count", 32'(count), 32'd0);
        chk("t4_instr", 32'(out_instr), 32'h0);
        step(1, 16'h7007, 16'h3036, 0, 0);
        chk("t4_after", 32'(out_instr), 32'h7007);
        chk("t4_after_count", 32'(count), 32'd1);
        step(0, 16'h0, 16'h0, 1, 1);
        step(0, 16'h0, 16'h0, 0, 1);
        chk("t4_dbl_flush", 32'(count), 32'd0);

        // streaming through the pointer wrap
        for (int i = 0; i < 10; i++) begin
            step(1, 16'h5000 + 16'(i), 16'h4000 + 16'(2 * i), 1, 0);
            chk("t5_instr", 32'(out_instr), 32'h5000 + 32'(i));
            chk("t5_count", 32'(count), 32'd1);
        end
        step(0, 16'h0, 16'h0, 1, 0);

        // reset while full, then idle
        step(1, 16'hA001, 16'h3040, 0, 0);
        step(1, 16'hB002, 16'h3042, 0, 0);
        reset_n   = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        flush     = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("t6_count", 32'(count), 32'd0);
        chk("t6_in_ready", 32'(in_ready), 32'd1);
        chk("t6_bubble5", 32'(bubble_cycles), 32'd5);

        // saturation
        repeat (65540) @(posedge clk);
        #1;
        chk("t6_sat", 32'(bubble_cycles), 32'hFFFF);
        step(1, 16'h9009, 16'h3050, 0, 0);
        step(0, 16'h0, 16'h0, 1, 0);
        step(0, 16'h0, 16'h0, 0, 0);
        chk("t6_sat_hold", 32'(bubble_cycles), 32'hFFFF);

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_decode_queue.md
Name: fetch_decode_queue

Overview:
- Decoupling buffer between the fetch stage and the decode stage of the pipelined LC-3b core.
- Accepts one fetched instruction per cycle, with its PC and PC+2, over a valid/ready handshake. Presents the oldest entry to decode over a second valid/ready handshake.
- Absorbs decode stalls without back-pressuring fetch combinationally.
- Discards all in-flight instructions on a branch/trap redirect.
- Outputs force 16'h0000 (LC-3b NOP, BR with no condition codes) whenever no valid instruction is presented, so decode sees a bubble.

Parameters:
- DEPTH, 2, number of instruction entries; must be a power of two, >= 2.
- CW, 2, count width; must equal clog2(DEPTH+1).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  reset, synchronous and active-low.
- flush  in  1  redirect from branch/trap resolution; discards all entries.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  queue can accept; equals (count < DEPTH).
- in_instr  in  16  fetched instruction word.
- in_pc  in  16  address of in_instr.
- in_pcplus2  in  16  in_pc + 2, as computed by fetch.
- out_valid  out  1  head entry valid; equals (count != 0).
- out_ready  in  1  decode accepts head this cycle.
- out_instr  out  16  head instruction; 16'h0000 when out_valid=0.
- out_pc  out  16  head PC; 16'h0000 when out_valid=0.
- out_pcplus2  out  16  head PC+2; 16'h0000 when out_valid=0.
- count  out  CW  current occupancy, 0..DEPTH.
- bubble_cycles  out  16  saturating count of cycles with out_valid=0 and reset_n=1.

Behaviour:
- Storage and pointers:
  - Circular storage of DEPTH entries of {instr, pc, pcplus2}.
  - wr_ptr and rd_ptr are log2(DEPTH) bits and wrap naturally modulo DEPTH.
- Reset (reset_n=0 at a rising edge):
  - wr_ptr=0, rd_ptr=0, count=0, bubble_cycles=0.
  - Hence out_valid=0, in_ready=1, and out_instr/out_pc/out_pcplus2=0.
  - Storage contents are don't-care.
  - Reset overrides flush and all handshakes, including mid-stream with the queue full.
- Push and pop:
  - push = in_valid & in_ready & ~flush; writes entry at wr_ptr, wr_ptr+1.
  - pop = out_valid & out_ready & ~flush; rd_ptr+1.
  - Simultaneous push & pop: count unchanged, both pointers advance. Legal at any count 1..DEPTH-1.
  - Full (count=DEPTH): in_ready=0, so in_valid is ignored even if out_ready=1 that cycle. There is no combinational in_ready<-out_ready path.
  - Empty (count=0): out_valid=0, and out_ready is ignored.
- Latency:
  - An instruction pushed in cycle N is visible on out_* with out_valid=1 in cycle N+1.
  - No same-cycle fall-through.
- Output:
  - out_* are combinational from storage[rd_ptr], AND-gated with out_valid.
- Ordering:
  - Strict FIFO order. Each accepted entry is delivered exactly once unless flushed.
- Flush (flush=1 at a rising edge, reset_n=1):
  - count=0 and rd_ptr=wr_ptr; pointers need not return to 0.
  - Any concurrent push is dropped and any concurrent pop is not counted.
  - out_valid=0 on the next cycle.
  - in_ready stays count<DEPTH during the flush cycle. Fetch treats a flush cycle as non-accepting regardless.
  - Back-to-back flushes are legal. A push in the cycle after flush is accepted normally.
- bubble_cycles:
  - Increments by 1 each cycle where reset_n=1 and out_valid=0.
  - Holds at 16'hFFFF; never wraps.
- Holding:
  - In-flight data and pointers hold when no push, pop or flush occurs.

Test Plan:
- Reset, then push 0x1234/pc 0x3000/pcplus2 0x3002 with out_ready=0 -> next cycle out_valid=1, out_instr=0x1234, out_pc=0x3000, count=1.
- Push 3 instructions A,B,C on consecutive cycles with out_ready=0, DEPTH=2 -> count=2 after B, in_ready=0; C not accepted; then out_ready=1 delivers A then B. C is accepted only once re-presented with in_ready=1.
- Full queue, in_valid=1 and out_ready=1 same cycle -> pop A only, count=1, no push. Next cycle push and pop together, count stays 1.
- Count=2, assert flush with in_valid=1 -> next cycle out_valid=0, count=0, out_instr=0x0000, the concurrent input is absent. Following push appears alone 1 cycle later.
- Wrap-around: stream 10 instructions with out_ready=1 continuously -> all 10 emerge in order, 1-cycle latency, count never exceeds 1.
- Hold reset_n=0 for 2 cycles with queue full, then release and idle 5 cycles -> count=0, in_ready=1, bubble_cycles=5. Saturation check: bubble_cycles reaches 0xFFFF and holds after 65536+ idle cycles.
